pairwise_and_reduce_seq: RTL



---
 rtl/pairwise_and_reduce_pkg.sv | 30 +++
 rtl/pairwise_and_reduce_seq_chunk_eval.sv | 19 +
 rtl/pairwise_and_reduce_seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/pairwise_and_reduce_pkg.sv
// Shared state encoding and chunk-level reduction helpers for pairwise_and_reduce_seq.
// The helpers take a fixed-width vector, so callers zero-extend their slice and CHUNK must not exceed MAX_CHUNK.
package pairwise_and_reduce_pkg;

  localparam int MAX_CHUNK = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned popcount_chunk(input logic [MAX_CHUNK-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_CHUNK; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  // Priority encoder: the downward loop lets the lowest set bit be the last one written.
  function automatic int unsigned lowest_set_bit(input logic [MAX_CHUNK-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_CHUNK - 1; i >= 0; i--) begin
      if (v[i]) idx = 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pairwise_and_reduce_seq_chunk_eval.sv
// Combinational evaluation of one CHUNK-lane slice of the product: any-set, popcount, lowest set lane.
module chunk_eval
  import pairwise_and_reduce_pkg::*;
#(
  parameter  int CHUNK = 16,
  localparam int PC_W  = $clog2(CHUNK + 1),
  localparam int LSB_W = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
  input  logic [CHUNK-1:0] i_slice,
  output logic             o_nonzero,
  output logic [PC_W-1:0]  o_popcount,
  output logic [LSB_W-1:0] o_lsb_index
);

  assign o_nonzero   = |i_slice;
  assign o_popcount  = PC_W'(popcount_chunk(MAX_CHUNK'(i_slice)));
  assign o_lsb_index = LSB_W'(lowest_set_bit(MAX_CHUNK'(i_slice)));

endmodule

// File: rtl/pairwise_and_reduce_seq.sv
// Chunked AND-reduce scanner: reports any-match, match count and lowest matching lane of A&B,
// evaluating CHUNK lanes per cycle between valid/ready handshakes.
module pairwise_and_reduce_seq
  import pairwise_and_reduce_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  parameter int CNT_W = $clog2(WIDTH + 1),
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_early_exit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_hit,
  output logic [CNT_W-1:0] out_count,
  output logic [IDX_W-1:0] out_first,
  output logic             busy
);

  localparam int N_CHUNKS = WIDTH / CHUNK;
  localparam int PTR_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int LANE_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PC_W     = $clog2(CHUNK + 1);
  localparam int LSB_W    = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_CHUNKS - 1);

  state_e            r_state;
  state_e            w_state_next;
  logic [WIDTH-1:0]  r_prod;
  logic              r_early_exit;
  logic [PTR_W-1:0]  r_ptr;
  logic              r_hit;
  logic [CNT_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_first;

  logic [LANE_W-1:0] w_base_lane;
  logic [CHUNK-1:0]  w_chunk;
  logic              w_nonzero;
  logic [PC_W-1:0]   w_popcount;
  logic [LSB_W-1:0]  w_lsb_index;
  logic              w_accept;
  logic              w_scan_end;

  // With CHUNK == WIDTH the pointer is always 0, so the truncated constant never matters.
  assign w_base_lane = LANE_W'(r_ptr) * LANE_W'(CHUNK);
  assign w_chunk     = r_prod[w_base_lane +: CHUNK];

  chunk_eval #(.CHUNK(CHUNK)) u_chunk_eval (
    .i_slice     (w_chunk),
    .o_nonzero   (w_nonzero),
    .o_popcount  (w_popcount),
    .o_lsb_index (w_lsb_index)
  );

  assign w_accept   = (r_state == IDLE) && in_valid;
  assign w_scan_end = (r_ptr == LAST_PTR) || (r_early_exit && w_nonzero);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)   w_state_next = SCAN;
      SCAN:    if (w_scan_end) w_state_next = DONE;
      DONE:    if (out_ready)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: the product register has no reset; it is only read in SCAN, which always follows a load.
  always_ff @(posedge clk) begin
    if (w_accept) r_prod <= in_a & in_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_early_exit <= 1'b0;
      r_ptr        <= '0;
      r_hit        <= 1'b0;
      r_count      <= '0;
      r_first      <= '0;
    end else if (w_accept) begin
      r_early_exit <= in_early_exit;
      r_ptr        <= '0;
      r_hit        <= 1'b0;
      r_count      <= '0;
      r_first      <= '0;
    end else if (r_state == SCAN) begin
      r_count <= r_count + CNT_W'(w_popcount);
      if (!r_hit && w_nonzero) begin
        r_hit   <= 1'b1;
        r_first <= IDX_W'(w_base_lane) + IDX_W'(w_lsb_index);
      end
      if (!w_scan_end) r_ptr <= r_ptr + PTR_W'(1);
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign out_hit   = r_hit;
  assign out_count = r_count;
  assign out_first = r_first;

endmodule
